mger_recovery: RTL and testbench

MGER_RECOVERY -- requirements
Module: mger_recovery

---
 rtl/mger_recovery.sv | 159 +++++++++++++++
 tb/tb_mger_recovery.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mger_recovery.sv
// mger_recovery: error-recovery adder that adds the masked error vector E
// (bits REC_LO..REC_HI) onto an approximate sum S, two bits per cycle,
// followed by a single-cycle carry ripple through the bits above REC_HI.
// Optional feature macro: MGER_EARLY_EXIT_EN. When it is defined, the group
// phase skips straight to the tail once the carry is 0 and no unresolved
// masked error bits remain.
module mger_recovery #(
    parameter int WIDTH  = 16,
    parameter int REC_LO = 5,
    parameter int REC_HI = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] E,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             cout
);

    localparam int NGROUPS   = (REC_HI - REC_LO + 2) / 2;
    localparam int GW        = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int TAIL_BITS = WIDTH - 1 - REC_HI;

    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [WIDTH-1:0] LOW_MASK = ONES >> (WIDTH - 1 - REC_HI);
    localparam logic [WIDTH-1:0] REC_MASK = LOW_MASK & (ONES << REC_LO);

    typedef enum logic [1:0] {
        IDLE,
        GROUP,
        TAIL,
        HOLD
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  s_reg;
    logic [WIDTH-1:0]  e_reg;
    logic [WIDTH-1:0]  z_reg;
    logic              cout_reg;
    logic [GW-1:0]     grp;
    logic              carry;

    int                v;
    logic              u_ok;
    logic [1:0]        s_pair;
    logic [1:0]        e_pair;
    logic [2:0]        grp_sum;
    logic [WIDTH-1:0]  grp_keep;
    logic [WIDTH-1:0]  grp_bits;
    logic [WIDTH-1:0]  z_group;
    logic              carry_group;
    logic              last_group;
    logic              early_exit;

    logic [WIDTH:0]    tail_sum;
    logic [WIDTH-1:0]  z_tail;
    logic              cout_tail;

    // Resolve the current two-bit group (or single-bit final group) and the tail ripple
    always_comb begin
        v           = REC_LO + 2 * int'(grp);
        u_ok        = (v + 1) <= REC_HI;
        s_pair      = 2'(s_reg >> v);
        e_pair      = 2'(e_reg >> v);
        grp_sum     = {2'b00, s_pair[0]} + {2'b00, e_pair[0]} + {2'b00, carry};
        if (u_ok) begin
            grp_sum = grp_sum + {1'b0, s_pair[1], 1'b0} + {1'b0, e_pair[1], 1'b0};
        end
        grp_keep    = u_ok ? ~(WIDTH'(3) << v) : ~(WIDTH'(1) << v);
        grp_bits    = u_ok ? (WIDTH'(grp_sum[1:0]) << v) : (WIDTH'(grp_sum[0]) << v);
        z_group     = (z_reg & grp_keep) | grp_bits;
        carry_group = u_ok ? grp_sum[2] : grp_sum[1];
        last_group  = (grp == GW'(NGROUPS - 1));

        tail_sum    = {1'b0, s_reg >> (REC_HI + 1)} + {{WIDTH{1'b0}}, carry};
        z_tail      = (z_reg & LOW_MASK) | (tail_sum[WIDTH-1:0] << (REC_HI + 1));
        cout_tail   = |tail_sum[WIDTH:TAIL_BITS];
    end

`ifdef MGER_EARLY_EXIT_EN
    assign early_exit = ~carry & ((e_reg >> v) == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Control FSM with registered handshake outputs and the working result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_reg     <= '0;
            e_reg     <= '0;
            z_reg     <= '0;
            cout_reg  <= 1'b0;
            grp       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_reg    <= S;
                        e_reg    <= E & REC_MASK;
                        z_reg    <= S;
                        cout_reg <= 1'b0;
                        grp      <= '0;
                        carry    <= 1'b0;
                        in_ready <= 1'b0;
                        if (mode) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= GROUP;
                        end
                    end
                end
                GROUP: begin
                    if (early_exit) begin
                        state <= TAIL;
                    end else begin
                        z_reg <= z_group;
                        carry <= carry_group;
                        grp   <= grp + GW'(1);
                        if (last_group) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    z_reg     <= z_tail;
                    cout_reg  <= cout_tail;
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign Z    = z_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_mger_recovery.sv
// tb_mger_recovery: directed and randomized checks of mger_recovery against
// a plain-arithmetic reference: {cout,Z} = S + (E & M) in recover mode,
// Z = S and cout = 0 in bypass mode.
module tb_mger_recovery;

    localparam int WIDTH    = 16;
    localparam int REC_LO   = 5;
    localparam int REC_HI   = 11;
    localparam int NGROUPS  = (REC_HI - REC_LO + 2) / 2;
    localparam int MAX_WAIT = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] S = '0;
    logic [WIDTH-1:0] E = '0;
    logic             mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] Z;
    logic             cout;

    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] rec_mask;

    mger_recovery #(
        .WIDTH (WIDTH),
        .REC_LO(REC_LO),
        .REC_HI(REC_HI)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S        (S),
        .E        (E),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Z        (Z),
        .cout     (cout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: accept, wait for the result, hold it under backpressure, release
    task automatic applyStimulus(input logic [WIDTH-1:0] s_in, input logic [WIDTH-1:0] e_in,
                                 input logic m, input int hold, input string tag);
        logic [WIDTH:0]   exp_sum;
        logic [WIDTH-1:0] exp_z;
        logic             exp_c;
        int               lat;
        bit               seen;
        if (m) exp_sum = {1'b0, s_in};
        else   exp_sum = {1'b0, s_in} + {1'b0, e_in & rec_mask};
        exp_z = exp_sum[WIDTH-1:0];
        exp_c = exp_sum[WIDTH];

        @(negedge clk);
        checkOutput({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        S = s_in;
        E = e_in;
        mode = m;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < MAX_WAIT) begin
            @(negedge clk);
            in_valid = 1'b0;
            S = WIDTH'($urandom);
            E = WIDTH'($urandom);
            mode = 1'($urandom);
            lat++;
            seen = (out_valid === 1'b1);
        end
        checkOutput({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (!seen) begin
            resetPulse();
            return;
        end

`ifdef MGER_EARLY_EXIT_EN
        if (m)
            checkOutput({tag, "_latency"}, 32'(lat), 32'd1);
        else if ((e_in & rec_mask) == '0)
            checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
        else
            checkOutput({tag, "_latency_range"}, 32'(lat >= 3 && lat <= NGROUPS + 2), 32'd1);
`else
        checkOutput({tag, "_latency"}, 32'(lat), m ? 32'd1 : 32'(NGROUPS + 2));
`endif
        checkOutput({tag, "_Z"}, 32'(Z), 32'(exp_z));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_c));
        checkOutput({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_Z"}, 32'(Z), 32'(exp_z));
            checkOutput({tag, "_hold_cout"}, 32'(cout), 32'(exp_c));
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Directed scenarios, mid-operation reset, then randomized transactions
    initial begin
        rec_mask = '0;
        for (int b = REC_LO; b <= REC_HI; b++) rec_mask[b] = 1'b1;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_Z", 32'(Z), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        applyStimulus(16'h07E0, 16'h0020, 1'b0, 0, "rec_carry_chain");
        applyStimulus(16'hFFFF, 16'h0FE0, 1'b0, 0, "rec_cout");
        applyStimulus(16'h1234, 16'hF01F, 1'b0, 0, "rec_outside_mask");
        applyStimulus(16'hABCD, 16'hFFFF, 1'b1, 0, "bypass");
        applyStimulus(16'hFFFF, 16'h0FE0, 1'b0, 10, "backpressure");
        applyStimulus(16'h0000, 16'hFFFF, 1'b0, 1, "rec_full_mask");

        @(negedge clk);
        S = 16'h07E0;
        E = 16'h0FE0;
        mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_Z", 32'(Z), 32'd0);
        checkOutput("midreset_cout", 32'(cout), 32'd0);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("midreset_no_stale", 32'(out_valid), 32'd0);
        end
        checkOutput("midreset_in_ready_after", 32'(in_ready), 32'd1);

        for (int n = 0; n < 24; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
